// File: rtl/lock_ctrl_param.sv
// Navigation-lock controller: per-direction request counters, a gate/water
// sequencing FSM and a prescaled water-level model.
module lock_ctrl_param #(
  parameter int LVL_W     = 8,
  parameter int LVL_MAX   = 100,
  parameter int LOW_THR   = 3,
  parameter int HIGH_THR  = 97,
  parameter int FILL_DIV  = 6,
  parameter int DRAIN_DIV = 4,
  parameter int QDEPTH    = 3,
  parameter int GATE_TO   = 50,
  localparam int CNT_W    = $clog2(QDEPTH + 1)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             arrive_req,
  input  logic             depart_req,
  input  logic             vessel_in,
  input  logic             vessel_out,
  input  logic             halt,
  output logic             upperGate,
  output logic             lowerGate,
  output logic             raiseWater,
  output logic             lowerWater,
  output logic [LVL_W-1:0] waterLevel,
  output logic             occupied,
  output logic [CNT_W-1:0] arr_cnt,
  output logic [CNT_W-1:0] dep_cnt,
  output logic [2:0]       state,
  output logic             ovf,
  output logic             timeout
);

  localparam int DIV_MAX = (FILL_DIV > DRAIN_DIV) ? FILL_DIV : DRAIN_DIV;
  localparam int PS_W    = $clog2(DIV_MAX + 1);
  localparam int TO_W    = $clog2(GATE_TO + 1);

  localparam logic [LVL_W-1:0] LV_MAX  = LVL_W'(LVL_MAX);
  localparam logic [LVL_W-1:0] LV_RST  = LVL_W'(LVL_MAX / 2);
  localparam logic [LVL_W-1:0] LV_LOW  = LVL_W'(LOW_THR);
  localparam logic [LVL_W-1:0] LV_HIGH = LVL_W'(HIGH_THR);
  localparam logic [PS_W-1:0]  PS_FILL_LAST  = PS_W'(FILL_DIV - 1);
  localparam logic [PS_W-1:0]  PS_DRAIN_LAST = PS_W'(DRAIN_DIV - 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(GATE_TO - 1);
  localparam logic [CNT_W-1:0] Q_MAX   = CNT_W'(QDEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DRAIN   = 3'd1,
    S_FILL    = 3'd2,
    S_OPEN_LO = 3'd3,
    S_OPEN_HI = 3'd4
  } state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  state_t           state_q, state_d;
  dir_t             dir_q, dir_d;
  dir_t             last_q, last_d;
  logic             occ_d;
  logic             arr_dec, dep_dec, to_fire;
  logic             take_arr, take_dep;
  logic             waiting_entry, to_last;
  logic [PS_W-1:0]  presc;
  logic [TO_W-1:0]  to_cnt;
  logic [CNT_W:0]   arr_step, dep_step;

  // Returns {overflow, next_count}; a simultaneous increment and decrement
  // cancel, so a full counter that is also being drained takes the request.
  function automatic logic [CNT_W:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                              input logic inc, input logic dec);
    logic [CNT_W:0] r;
    r = {1'b0, cnt};
    if (inc && !dec) begin
      if (cnt == Q_MAX) r[CNT_W] = 1'b1;
      else              r[CNT_W-1:0] = cnt + 1'b1;
    end else if (dec && !inc && cnt != '0) begin
      r[CNT_W-1:0] = cnt - 1'b1;
    end
    return r;
  endfunction

  assign state      = state_q;
  assign lowerWater = (state_q == S_DRAIN);
  assign raiseWater = (state_q == S_FILL);
  assign lowerGate  = (state_q == S_OPEN_LO);
  assign upperGate  = (state_q == S_OPEN_HI);

  // An open gate is only timed while it waits for the vessel to enter.
  assign waiting_entry = !occupied &&
                         ((state_q == S_OPEN_LO && dir_q == DIR_UP) ||
                          (state_q == S_OPEN_HI && dir_q == DIR_DOWN));
  assign to_last  = (to_cnt == TO_LAST);
  assign take_arr = (arr_cnt != '0) && ((dep_cnt == '0) || (last_q == DIR_DOWN));
  assign take_dep = (dep_cnt != '0) && !take_arr;
  assign arr_step = cnt_step(arr_cnt, arrive_req, arr_dec);
  assign dep_step = cnt_step(dep_cnt, depart_req, dep_dec);

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    dir_d   = dir_q;
    last_d  = last_q;
    occ_d   = occupied;
    arr_dec = 1'b0;
    dep_dec = 1'b0;
    to_fire = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!halt && take_arr) begin
          dir_d   = DIR_UP;
          last_d  = DIR_UP;
          state_d = (waterLevel <= LV_LOW) ? S_OPEN_LO : S_DRAIN;
        end else if (!halt && take_dep) begin
          dir_d   = DIR_DOWN;
          last_d  = DIR_DOWN;
          state_d = (waterLevel >= LV_HIGH) ? S_OPEN_HI : S_FILL;
        end
      end
      S_DRAIN: if (waterLevel <= LV_LOW)  state_d = S_OPEN_LO;
      S_FILL:  if (waterLevel >= LV_HIGH) state_d = S_OPEN_HI;
      S_OPEN_LO: begin
        if (waiting_entry) begin
          if (vessel_in) begin
            occ_d   = 1'b1;
            arr_dec = 1'b1;
            state_d = S_FILL;
          end else if (to_last) begin
            arr_dec = 1'b1;
            to_fire = 1'b1;
            state_d = S_IDLE;
          end
        end else if (occupied && dir_q == DIR_DOWN && vessel_out) begin
          occ_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_OPEN_HI: begin
        if (waiting_entry) begin
          if (vessel_in) begin
            occ_d   = 1'b1;
            dep_dec = 1'b1;
            state_d = S_DRAIN;
          end else if (to_last) begin
            dep_dec = 1'b1;
            to_fire = 1'b1;
            state_d = S_IDLE;
          end
        end else if (occupied && dir_q == DIR_UP && vessel_out) begin
          occ_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      dir_q      <= DIR_UP;
      last_q     <= DIR_DOWN;
      occupied   <= 1'b0;
      arr_cnt    <= '0;
      dep_cnt    <= '0;
      ovf        <= 1'b0;
      timeout    <= 1'b0;
      to_cnt     <= '0;
      presc      <= '0;
      waterLevel <= LV_RST;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      last_q   <= last_d;
      occupied <= occ_d;
      arr_cnt  <= arr_step[CNT_W-1:0];
      dep_cnt  <= dep_step[CNT_W-1:0];
      ovf      <= arr_step[CNT_W] | dep_step[CNT_W];
      timeout  <= to_fire;

      if (waiting_entry && !vessel_in && !to_last) to_cnt <= to_cnt + 1'b1;
      else                                          to_cnt <= '0;

      if (raiseWater) begin
        if (presc == PS_FILL_LAST) begin
          presc <= '0;
          if (waterLevel != LV_MAX) waterLevel <= waterLevel + 1'b1;
        end else begin
          presc <= presc + 1'b1;
        end
      end else if (lowerWater) begin
        if (presc == PS_DRAIN_LAST) begin
          presc <= '0;
          if (waterLevel != '0) waterLevel <= waterLevel - 1'b1;
        end else begin
          presc <= presc + 1'b1;
        end
      end else begin
        presc <= '0;
      end
    end
  end

endmodule
